// File: rtl/decode_queue_if.sv
// Handshake bundle between the fetcher, the decode queue and dispatch.
// The queue side uses the slave modport; the fetch/dispatch side (or a
// testbench standing in for both) uses the master modport.
interface decode_queue_if #(
  parameter int IQ_DEPTH_BIT = 3,
  parameter int ADDR_W       = 32
);
  // Fetch -> queue
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_addr;
  logic [31:0]           in_data;

  // Queue -> dispatch
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_class;
  logic [2:0]            out_funct3;
  logic                  out_alt;
  logic [4:0]            out_rd;
  logic [4:0]            out_rs1;
  logic [4:0]            out_rs2;
  logic [31:0]           out_imm;
  logic [ADDR_W-1:0]     out_pc;

  // Occupancy
  logic [IQ_DEPTH_BIT:0] count;

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_funct3, out_alt,
           out_rd, out_rs1, out_rs2, out_imm, out_pc, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_class, out_funct3, out_alt,
           out_rd, out_rs1, out_rs2, out_imm, out_pc, count
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage between fetch and dispatch.
// Each accepted instruction word is decoded into a micro-op (class, funct3,
// alt bit, register indices, sign-extended immediate, pc) and written into a
// circular queue of 2**IQ_DEPTH_BIT entries, so fetch can keep running while
// dispatch stalls. rob_clear empties the queue in one cycle.
//
// Optional feature macro: DECODE_ILLEGAL_EN
//   defined   : unknown opcodes are queued as class 15 (ILLEGAL) and the
//               queue stops accepting words until rst_in or rob_clear.
//   undefined : unknown opcodes are queued as a NOP (ARITH_I, x0, imm 0)
//               and the queue never halts.
module decode_queue #(
  parameter int IQ_DEPTH_BIT = 3,
  parameter int ADDR_W       = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          rob_clear,
  decode_queue_if.slave q
);

  localparam int DEPTH = 2 ** IQ_DEPTH_BIT;

  typedef logic [IQ_DEPTH_BIT-1:0] ptr_t;
  typedef logic [IQ_DEPTH_BIT:0]   cnt_t;

  localparam ptr_t PTR_ZERO = ptr_t'(1'b0);
  localparam ptr_t PTR_ONE  = ptr_t'(1'b1);
  localparam cnt_t CNT_ZERO = cnt_t'(1'b0);
  localparam cnt_t CNT_ONE  = cnt_t'(1'b1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  // Micro-op classes
  localparam logic [3:0] CLS_ARITH_R = 4'd0;
  localparam logic [3:0] CLS_ARITH_I = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_STORE   = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_JAL     = 4'd5;
  localparam logic [3:0] CLS_JALR    = 4'd6;
  localparam logic [3:0] CLS_AUIPC   = 4'd7;
  localparam logic [3:0] CLS_LUI     = 4'd8;
`ifdef DECODE_ILLEGAL_EN
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;
`endif

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic [3:0]        cls;
    logic [2:0]        funct3;
    logic              alt;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic [ADDR_W-1:0] pc;
  } uop_t;

  // Immediate extraction helpers, one per instruction format.
  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Full RV32I word -> micro-op decode. Register fields a class does not use
  // stay 0 so dispatch never sees false dependencies.
  function automatic uop_t decode_word(input logic [31:0] inst,
                                       input logic [ADDR_W-1:0] pc);
    uop_t u;
    u        = '0;
    u.pc     = pc;
    u.funct3 = inst[14:12];
    case (inst[6:0])
      OP_R: begin
        u.cls = CLS_ARITH_R;
        u.alt = inst[30];
        u.rd  = inst[11:7];
        u.rs1 = inst[19:15];
        u.rs2 = inst[24:20];
      end
      OP_I: begin
        u.cls = CLS_ARITH_I;
        u.rd  = inst[11:7];
        u.rs1 = inst[19:15];
        // Shifts (funct3 001/101) carry a 5-bit shamt; only SRAI uses alt
        if (inst[13:12] == 2'b01) begin
          u.imm = {27'h0000000, inst[24:20]};
          u.alt = inst[14] & inst[30];
        end else begin
          u.imm = imm_i(inst);
          u.alt = 1'b0;
        end
      end
      OP_LOAD: begin
        u.cls = CLS_LOAD;
        u.rd  = inst[11:7];
        u.rs1 = inst[19:15];
        u.imm = imm_i(inst);
      end
      OP_STORE: begin
        u.cls = CLS_STORE;
        u.rs1 = inst[19:15];
        u.rs2 = inst[24:20];
        u.imm = imm_s(inst);
      end
      OP_BRANCH: begin
        u.cls = CLS_BRANCH;
        u.rs1 = inst[19:15];
        u.rs2 = inst[24:20];
        u.imm = imm_b(inst);
      end
      OP_JAL: begin
        u.cls = CLS_JAL;
        u.rd  = inst[11:7];
        u.imm = imm_j(inst);
      end
      OP_JALR: begin
        u.cls = CLS_JALR;
        u.rd  = inst[11:7];
        u.rs1 = inst[19:15];
        u.imm = imm_i(inst);
      end
      OP_AUIPC: begin
        u.cls = CLS_AUIPC;
        u.rd  = inst[11:7];
        u.imm = imm_u(inst);
      end
      OP_LUI: begin
        u.cls = CLS_LUI;
        u.rd  = inst[11:7];
        u.imm = imm_u(inst);
      end
      default: begin
`ifdef DECODE_ILLEGAL_EN
        u.cls    = CLS_ILLEGAL;
`else
        // Unknown opcode degrades to addi x0,x0,0
        u.cls    = CLS_ARITH_I;
`endif
        u.funct3 = 3'b000;
      end
    endcase
    return u;
  endfunction

  // Queue storage and control state
  uop_t  mem_r [DEPTH];
  ptr_t  head_r;
  ptr_t  tail_r;
  cnt_t  count_r;

  // Combinational signals
  uop_t  dec_s;
  uop_t  head_s;
  cnt_t  count_nxt_s;
  logic  full_s;
  logic  empty_s;
  logic  in_ready_s;
  logic  push_s;
  logic  pop_s;
  logic  flush_s;

`ifdef DECODE_ILLEGAL_EN
  logic  halted_r;
  logic  illegal_s;
`endif

  assign flush_s = rst_in | rob_clear;
  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);
  assign dec_s   = decode_word(q.in_data, q.in_addr);

`ifdef DECODE_ILLEGAL_EN
  assign illegal_s  = (dec_s.cls == CLS_ILLEGAL);
  assign in_ready_s = rdy_in & ~full_s & ~halted_r;
`else
  assign in_ready_s = rdy_in & ~full_s;
`endif

  // in_ready deliberately ignores out_ready: a full queue refuses the word
  // even in a cycle where dispatch frees a slot.
  assign push_s = q.in_valid & in_ready_s;
  assign pop_s  = ~empty_s & q.out_ready & rdy_in;

  // Next occupancy from the push/pop pair
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer/occupancy update: reset and flush win over the rdy_in freeze
  always_ff @(posedge clk_in) begin
    if (flush_s) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (rdy_in) begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  // Halt flag: set once an illegal word is queued, cleared only by flush
  always_ff @(posedge clk_in) begin
    if (flush_s) begin
      halted_r <= 1'b0;
    end else if (push_s && illegal_s) begin
      halted_r <= 1'b1;
    end
  end
`endif

  // Entry write at the tail; a flush in the same cycle drops the word
  always_ff @(posedge clk_in) begin
    if (!flush_s && push_s) begin
      mem_r[tail_r] <= dec_s;
    end
  end

  // Head view: all-zero whenever the queue is empty
  always_comb begin
    head_s = '0;
    if (empty_s) begin
      head_s = '0;
    end else begin
      head_s = mem_r[head_r];
    end
  end

  assign q.in_ready   = in_ready_s;
  assign q.out_valid  = ~empty_s;
  assign q.out_class  = head_s.cls;
  assign q.out_funct3 = head_s.funct3;
  assign q.out_alt    = head_s.alt;
  assign q.out_rd     = head_s.rd;
  assign q.out_rs1    = head_s.rs1;
  assign q.out_rs2    = head_s.rs2;
  assign q.out_imm    = head_s.imm;
  assign q.out_pc     = head_s.pc;
  assign q.count      = count_r;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: the driver records the hand-decoded
// micro-op of every accepted word, a negedge monitor compares each popped
// head entry against the oldest recorded one.
module tb_decode_queue;

  localparam int IQB = 3;
  localparam int AW  = 32;

  typedef struct packed {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
  } uop_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic rob_clear;

  int   checks = 0;
  int   errors = 0;
  uop_t exp_q[$];
  uop_t cur_exp;
  uop_t mon_exp;
  uop_t mon_act;

  always #5 clk_in = ~clk_in;

  decode_queue_if #(.IQ_DEPTH_BIT(IQB), .ADDR_W(AW)) dq ();

  decode_queue #(.IQ_DEPTH_BIT(IQB), .ADDR_W(AW)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .rob_clear (rob_clear),
    .q         (dq)
  );

  function automatic uop_t mk(input logic [3:0] c, input logic [2:0] f3,
                              input logic alt, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
    uop_t u;
    u = '{cls: c, f3: f3, alt: alt, rd: rd, rs1: rs1, rs2: rs2, imm: imm, pc: 32'h0};
    return u;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // One clock: record acceptance mid-cycle, then move past the next edge
  task automatic step();
    @(negedge clk_in);
    if (rst_in || rob_clear) begin
      exp_q.delete();
    end else if (dq.in_valid && dq.in_ready) begin
      exp_q.push_back(cur_exp);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] w, input uop_t e);
    dq.in_valid = 1'b1;
    dq.in_addr  = pc;
    dq.in_data  = w;
    cur_exp     = e;
    cur_exp.pc  = pc;
    step();
    dq.in_valid = 1'b0;
  endtask

  // Monitor: every completed pop is compared against the scoreboard
  always @(negedge clk_in) begin
    if (!rst_in && !rob_clear && rdy_in && dq.out_valid && dq.out_ready) begin
      mon_act = {dq.out_class, dq.out_funct3, dq.out_alt, dq.out_rd,
                 dq.out_rs1, dq.out_rs2, dq.out_imm, dq.out_pc};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, expected no output", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL pop_uop: got %h, expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    rob_clear    = 1'b0;
    dq.in_valid  = 1'b0;
    dq.in_addr   = 32'h0;
    dq.in_data   = 32'h0;
    dq.out_ready = 1'b0;
    cur_exp      = '0;
    repeat (2) step();
    rst_in = 1'b0;

    // Reset state
    chk("rst_count",     32'(dq.count), 32'd0);
    chk("rst_out_valid", 32'(dq.out_valid), 32'd0);
    chk("rst_in_ready",  32'(dq.in_ready), 32'd1);
    chk("rst_out_imm",   dq.out_imm, 32'h0);

    // 1: addi x1,x0,5 visible one edge later
    push_word(32'h0, 32'h00500093, mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
    chk("t1_out_valid", 32'(dq.out_valid), 32'd1);
    chk("t1_class",     32'(dq.out_class), 32'd1);
    chk("t1_rd",        32'(dq.out_rd), 32'd1);
    chk("t1_rs1",       32'(dq.out_rs1), 32'd0);
    chk("t1_imm",       dq.out_imm, 32'd5);
    dq.out_ready = 1'b1;
    step();
    dq.out_ready = 1'b0;
    chk("t1_count_after_pop", 32'(dq.count), 32'd0);

    // 2: fill eight entries with dispatch stalled
    push_word(32'h04, 32'h002081B3, mk(4'd0, 3'd0, 1'b0, 5'd3,  5'd1, 5'd2,  32'h0));        // add x3,x1,x2
    push_word(32'h08, 32'h407302B3, mk(4'd0, 3'd0, 1'b1, 5'd5,  5'd6, 5'd7,  32'h0));        // sub x5,x6,x7
    push_word(32'h0C, 32'h40325213, mk(4'd1, 3'd5, 1'b1, 5'd4,  5'd4, 5'd0,  32'd3));        // srai x4,x4,3
    push_word(32'h10, 32'hFF812503, mk(4'd2, 3'd2, 1'b0, 5'd10, 5'd2, 5'd0,  32'hFFFFFFF8)); // lw x10,-8(x2)
    push_word(32'h14, 32'h00B12623, mk(4'd3, 3'd2, 1'b0, 5'd0,  5'd2, 5'd11, 32'd12));       // sw x11,12(x2)
    push_word(32'h18, 32'h010000EF, mk(4'd5, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0,  32'd16));       // jal x1,+16
    push_word(32'h1C, 32'h00008067, mk(4'd6, 3'd0, 1'b0, 5'd0,  5'd1, 5'd0,  32'h0));        // jalr x0,0(x1)
    push_word(32'h20, 32'h123452B7, mk(4'd8, 3'd5, 1'b0, 5'd5,  5'd0, 5'd0,  32'h12345000)); // lui x5,0x12345
    chk("t2_count_full", 32'(dq.count), 32'd8);
    chk("t2_in_ready",   32'(dq.in_ready), 32'd0);
    push_word(32'h24, 32'hFFFFF397, mk(4'd7, 3'd7, 1'b0, 5'd7, 5'd0, 5'd0, 32'hFFFFF000));   // rejected
    chk("t2_count_9th",  32'(dq.count), 32'd8);
    chk("t2_head_class", 32'(dq.out_class), 32'd0);
    chk("t2_head_rd",    32'(dq.out_rd), 32'd3);
    chk("t2_head_pc",    dq.out_pc, 32'h04);

    // 3: full + in_valid + out_ready pops only; then wrap the pointers
    dq.out_ready = 1'b1;
    push_word(32'h24, 32'hFFFFF397, mk(4'd7, 3'd7, 1'b0, 5'd7, 5'd0, 5'd0, 32'hFFFFF000));
    chk("t3_count_7", 32'(dq.count), 32'd7);
    dq.out_ready = 1'b0;
    push_word(32'h24, 32'hFFFFF397, mk(4'd7, 3'd7, 1'b0, 5'd7, 5'd0, 5'd0, 32'hFFFFF000));   // auipc x7
    chk("t3_count_refill", 32'(dq.count), 32'd8);
    dq.out_ready = 1'b1;
    repeat (8) step();
    dq.out_ready = 1'b0;
    chk("t3_count_drained", 32'(dq.count), 32'd0);
    chk("t3_out_valid",     32'(dq.out_valid), 32'd0);
    chk("t3_sb_empty",      32'(exp_q.size()), 32'd0);

    // 4: flush with five entries queued and a word on the input
    push_word(32'h30, 32'h00500093, mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
    push_word(32'h34, 32'h002081B3, mk(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0));
    push_word(32'h38, 32'h407302B3, mk(4'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'h0));
    push_word(32'h3C, 32'hFF812503, mk(4'd2, 3'd2, 1'b0, 5'd10, 5'd2, 5'd0, 32'hFFFFFFF8));
    push_word(32'h40, 32'h00B12623, mk(4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd11, 32'd12));
    chk("t4_count_5", 32'(dq.count), 32'd5);
    rob_clear = 1'b1;
    push_word(32'h44, 32'h010000EF, mk(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16));
    rob_clear = 1'b0;
    chk("t4_count",     32'(dq.count), 32'd0);
    chk("t4_out_valid", 32'(dq.out_valid), 32'd0);
    chk("t4_class",     32'(dq.out_class), 32'd0);
    chk("t4_rd",        32'(dq.out_rd), 32'd0);
    chk("t4_rs1",       32'(dq.out_rs1), 32'd0);
    chk("t4_imm",       dq.out_imm, 32'h0);
    chk("t4_pc",        dq.out_pc, 32'h0);
    step();
    chk("t4_count_stays", 32'(dq.count), 32'd0);

    // rdy_in low freezes everything; rob_clear still flushes
    push_word(32'h50, 32'h00500093, mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
    push_word(32'h54, 32'h002081B3, mk(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0));
    rdy_in       = 1'b0;
    dq.out_ready = 1'b1;
    push_word(32'h58, 32'hFF812503, mk(4'd2, 3'd2, 1'b0, 5'd10, 5'd2, 5'd0, 32'hFFFFFFF8));
    push_word(32'h58, 32'hFF812503, mk(4'd2, 3'd2, 1'b0, 5'd10, 5'd2, 5'd0, 32'hFFFFFFF8));
    chk("hold_count",    32'(dq.count), 32'd2);
    chk("hold_in_ready", 32'(dq.in_ready), 32'd0);
    chk("hold_head_pc",  dq.out_pc, 32'h50);
    rob_clear = 1'b1;
    step();
    rob_clear    = 1'b0;
    dq.out_ready = 1'b0;
    chk("hold_clear_count", 32'(dq.count), 32'd0);
    rdy_in = 1'b1;

    // 5: beq x0,x0,-4 at pc 0x100
    push_word(32'h100, 32'hFE000EE3, mk(4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC));
    chk("t5_class", 32'(dq.out_class), 32'd4);
    chk("t5_imm",   dq.out_imm, 32'hFFFFFFFC);
    chk("t5_pc",    dq.out_pc, 32'h100);
    dq.out_ready = 1'b1;
    step();
    dq.out_ready = 1'b0;

    // 6: all-ones word (unknown opcode)
`ifdef DECODE_ILLEGAL_EN
    push_word(32'h200, 32'hFFFFFFFF, mk(4'd15, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0));
    chk("t6_class",    32'(dq.out_class), 32'd15);
    chk("t6_in_ready", 32'(dq.in_ready), 32'd0);
`else
    push_word(32'h200, 32'hFFFFFFFF, mk(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0));
    chk("t6_class",    32'(dq.out_class), 32'd1);
    chk("t6_in_ready", 32'(dq.in_ready), 32'd1);
`endif
    dq.out_ready = 1'b1;
    step();
    dq.out_ready = 1'b0;
    push_word(32'h204, 32'h00500093, mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5));
`ifdef DECODE_ILLEGAL_EN
    chk("t6_halt_count",    32'(dq.count), 32'd0);
    chk("t6_halt_in_ready", 32'(dq.in_ready), 32'd0);
`else
    chk("t6_nohalt_count",    32'(dq.count), 32'd1);
    chk("t6_nohalt_in_ready", 32'(dq.in_ready), 32'd1);
`endif
    rob_clear = 1'b1;
    step();
    rob_clear = 1'b0;
    chk("t6_clear_in_ready", 32'(dq.in_ready), 32'd1);
    chk("t6_clear_count",    32'(dq.count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
